// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Imported by the arbiter top and its burst address generator.
package dmem_arb_pkg;

  localparam int LEN_W_DEF = 4;

  localparam logic [3:0] XFER_B = 4'd1;
  localparam logic [3:0] XFER_H = 4'd2;
  localparam logic [3:0] XFER_W = 4'd4;
  localparam logic [3:0] XFER_D = 4'd8;

  typedef enum logic {
    ARB_IDLE      = 1'b0,
    ARB_DMA_BURST = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/dmem_arbiter_burst_addr_gen.sv
// DMA burst sequencer: holds the next beat address, stride and
// remaining beat count; flags the final beat of a burst.
module burst_addr_gen
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_base,
  input  logic [3:0]        i_size,
  input  logic [LEN_W-1:0]  i_len,
  output logic [DATA_W-1:0] o_addr,
  output logic [3:0]        o_size,
  output logic              o_last_beat
);

  logic [DATA_W-1:0] r_base;
  logic [3:0]        r_size;
  logic [LEN_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_in_stride;
  logic [DATA_W-1:0] w_stride;

  assign w_in_stride = {{(DATA_W-4){1'b0}}, i_size};
  assign w_stride    = {{(DATA_W-4){1'b0}}, r_size};

  // r_base tracks the address of the beat that issues next;
  // beat 0 is driven straight from the request, so load skips it.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_base <= '0;
      r_size <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_base <= i_base + w_in_stride;
      r_size <= i_size;
      r_cnt  <= i_len;
    end else if (i_step) begin
      r_base <= r_base + w_stride;
      r_cnt  <= r_cnt - LEN_W'(1);
    end
  end

  assign o_addr      = r_base;
  assign o_size      = r_size;
  assign o_last_beat = (r_cnt == LEN_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates datamem between the CPU memory stage and a DMA port,
// sequencing DMA bursts and returning read data to the owner.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_xfer_size,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [3:0]        dma_xfer_size,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [3:0]        mem_xfer_size,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_t        r_state;
  arb_owner_t        r_owner;
  logic              r_we;
  logic              r_done;
  logic              r_cpu_rvalid;
  logic              r_dma_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic              w_idle;
  logic              w_cpu_gnt;
  logic              w_dma_gnt;
  logic              w_we;
  logic              w_any;
  logic              w_load;
  logic              w_step;
  logic              w_clear;
  logic              w_last;
  logic              w_single;
  logic              w_burst_end;
  logic [DATA_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0]        w_size;
  logic [DATA_W-1:0] w_burst_addr;
  logic [3:0]        w_burst_size;

  assign w_idle = (r_state == ARB_IDLE);

  // Reset masks grants so nothing reaches datamem while it is held.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (!reset) begin
      if (w_idle) begin
        w_cpu_gnt = cpu_req &
                    (!dma_req || r_owner == OWN_DMA);
        w_dma_gnt = dma_req &
                    (!cpu_req || r_owner == OWN_CPU);
      end else begin
        w_dma_gnt = dma_req;
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_size  = '0;
    w_we    = 1'b0;
    if (w_cpu_gnt) begin
      w_addr  = cpu_addr;
      w_wdata = cpu_wdata;
      w_size  = cpu_xfer_size;
      w_we    = cpu_we;
    end else if (w_dma_gnt) begin
      w_wdata = dma_wdata;
      if (w_idle) begin
        w_addr = dma_addr;
        w_size = dma_xfer_size;
        w_we   = dma_we;
      end else begin
        w_addr = w_burst_addr;
        w_size = w_burst_size;
        w_we   = r_we;
      end
    end
  end

  assign w_any = w_cpu_gnt | w_dma_gnt;

  assign w_single    = w_idle & w_dma_gnt &
                       (dma_len == '0);
  assign w_load      = w_idle & w_dma_gnt &
                       (dma_len != '0);
  assign w_step      = !w_idle & w_dma_gnt & !w_last;
  assign w_burst_end = !w_idle & w_dma_gnt & w_last;
  assign w_clear     = !w_idle & (!dma_req | w_last);

  burst_addr_gen #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_gen (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_clear     (w_clear),
    .i_base      (dma_addr),
    .i_size      (dma_xfer_size),
    .i_len       (dma_len),
    .o_addr      (w_burst_addr),
    .o_size      (w_burst_size),
    .o_last_beat (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_owner      <= OWN_DMA;
      r_we         <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_done       <= w_single | w_burst_end;
      r_cpu_rvalid <= w_cpu_gnt & !w_we;
      r_dma_rvalid <= w_dma_gnt & !w_we;
      if (w_cpu_gnt && !w_we)
        r_cpu_rdata <= mem_read_data;
      if (w_dma_gnt && !w_we)
        r_dma_rdata <= mem_read_data;
      if (w_cpu_gnt)
        r_owner <= OWN_CPU;
      else if (w_dma_gnt)
        r_owner <= OWN_DMA;
      if (w_load) begin
        r_state <= ARB_DMA_BURST;
        r_we    <= dma_we;
      end else if (w_clear) begin
        r_state <= ARB_IDLE;
      end
    end
  end

  assign cpu_gnt          = w_cpu_gnt;
  assign dma_gnt          = w_dma_gnt;
  assign cpu_rvalid       = r_cpu_rvalid;
  assign cpu_rdata        = r_cpu_rdata;
  assign dma_rvalid       = r_dma_rvalid;
  assign dma_rdata        = r_dma_rdata;
  assign dma_done         = r_done;
  assign mem_address      = w_addr;
  assign mem_write_data   = w_wdata;
  assign mem_xfer_size    = w_size;
  assign mem_write_enable = w_any & w_we;
  assign mem_read_enable  = w_any & !w_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors push
// expected bus beats, read returns and done pulses per cycle.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    logic        who;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wd;
    logic [3:0]  sz;
    int          at;
  } gnt_t;

  typedef struct {
    logic [63:0] d;
    int          at;
  } rd_t;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [63:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_xfer_size;
  logic        cpu_gnt, cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [63:0] dma_addr, dma_wdata;
  logic [3:0]  dma_xfer_size;
  logic [3:0]  dma_len;
  logic        dma_gnt, dma_rvalid, dma_done;
  logic [63:0] dma_rdata;
  logic [63:0] mem_address, mem_write_data;
  logic        mem_write_enable, mem_read_enable;
  logic [3:0]  mem_xfer_size;
  logic [63:0] rd_val;

  gnt_t q_gnt[$];
  rd_t  q_crd[$];
  rd_t  q_drd[$];
  int   q_done[$];

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  dmem_arbiter #(.DATA_W(64), .LEN_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_xfer_size    (cpu_xfer_size),
    .cpu_gnt          (cpu_gnt),
    .cpu_rvalid       (cpu_rvalid),
    .cpu_rdata        (cpu_rdata),
    .dma_req          (dma_req),
    .dma_we           (dma_we),
    .dma_addr         (dma_addr),
    .dma_wdata        (dma_wdata),
    .dma_xfer_size    (dma_xfer_size),
    .dma_len          (dma_len),
    .dma_gnt          (dma_gnt),
    .dma_rvalid       (dma_rvalid),
    .dma_rdata        (dma_rdata),
    .dma_done         (dma_done),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_xfer_size    (mem_xfer_size),
    .mem_read_data    (rd_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, req);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s cyc=%0d", nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input logic who,
                         input logic [63:0] a,
                         input logic w,
                         input logic [63:0] d,
                         input logic [3:0] s,
                         input int at);
    gnt_t e;
    e.who = who; e.addr = a; e.we = w;
    e.wd = d; e.sz = s; e.at = at;
    q_gnt.push_back(e);
  endtask

  task automatic exp_rd(input logic who,
                        input logic [63:0] d,
                        input int at);
    rd_t e;
    e.d = d; e.at = at;
    if (who) q_drd.push_back(e);
    else     q_crd.push_back(e);
  endtask

  // Monitor: pops and compares whenever the DUT presents an event.
  always @(negedge clk) begin
    gnt_t g;
    rd_t  r;
    int   t;
    logic [63:0] bus;
    if (cpu_gnt && dma_gnt) bad("gnt_both");
    if (cpu_gnt || dma_gnt) begin
      if (q_gnt.size() == 0) bad("gnt_unexpected");
      else begin
        g = q_gnt.pop_front();
        chk("gnt_cyc", 64'(cyc), 64'(g.at));
        chk("gnt_who", {63'b0, dma_gnt}, {63'b0, g.who});
        chk("mem_addr", mem_address, g.addr);
        chk("mem_wdata", mem_write_data, g.wd);
        chk("mem_size", {60'b0, mem_xfer_size}, {60'b0, g.sz});
        chk("mem_en", {62'b0, mem_write_enable, mem_read_enable},
            {62'b0, g.we, !g.we});
      end
    end else begin
      if (q_gnt.size() != 0 && q_gnt[0].at <= cyc)
        bad("gnt_missing");
      bus = mem_address | mem_write_data |
            {60'b0, mem_xfer_size} |
            {62'b0, mem_write_enable, mem_read_enable};
      chk("idle_bus", bus, 64'b0);
    end
    if (cpu_rvalid) begin
      if (q_crd.size() == 0) bad("cpu_rvalid_unexpected");
      else begin
        r = q_crd.pop_front();
        chk("cpu_rd_cyc", 64'(cyc), 64'(r.at));
        chk("cpu_rdata", cpu_rdata, r.d);
      end
    end else if (q_crd.size() != 0 && q_crd[0].at <= cyc)
      bad("cpu_rvalid_missing");
    if (dma_rvalid) begin
      if (q_drd.size() == 0) bad("dma_rvalid_unexpected");
      else begin
        r = q_drd.pop_front();
        chk("dma_rd_cyc", 64'(cyc), 64'(r.at));
        chk("dma_rdata", dma_rdata, r.d);
      end
    end else if (q_drd.size() != 0 && q_drd[0].at <= cyc)
      bad("dma_rvalid_missing");
    if (dma_done) begin
      if (q_done.size() == 0) bad("done_unexpected");
      else begin
        t = q_done.pop_front();
        chk("done_cyc", 64'(cyc), 64'(t));
      end
    end else if (q_done.size() != 0 && q_done[0] <= cyc)
      bad("done_missing");
  end

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0;
    cpu_wdata = 0; cpu_xfer_size = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0;
    dma_wdata = 0; dma_xfer_size = 0; dma_len = 0;
    rd_val = 0;
    repeat (2) tick();

    // reset overrides a simultaneous request
    cpu_req = 1; cpu_addr = 64'h10; cpu_xfer_size = XFER_D;
    @(negedge clk);
    chk("rst_cpu_gnt", {63'b0, cpu_gnt}, 64'd0);
    chk("rst_rvalid", {62'b0, cpu_rvalid, dma_rvalid}, 64'd0);
    chk("rst_done", {63'b0, dma_done}, 64'd0);
    chk("rst_cpu_rdata", cpu_rdata, 64'd0);
    chk("rst_dma_rdata", dma_rdata, 64'd0);

    // tie after reset: CPU first, then DMA single beat
    tick();
    reset = 0;
    dma_req = 1; dma_we = 1; dma_addr = 64'h400;
    dma_wdata = 64'hAB; dma_xfer_size = XFER_D; dma_len = 0;
    rd_val = 64'h33;
    exp_gnt(0, 64'h10, 0, 64'h0, 8, cyc);
    exp_rd(0, 64'h33, cyc + 1);
    tick();
    cpu_req = 0;
    exp_gnt(1, 64'h400, 1, 64'hAB, 8, cyc);
    q_done.push_back(cyc + 1);
    tick();
    dma_req = 0;

    // write burst with CPU requesting throughout
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 64'h80;
    cpu_wdata = 64'h1111; cpu_xfer_size = XFER_W;
    dma_req = 1; dma_we = 1; dma_addr = 64'h100;
    dma_xfer_size = XFER_D; dma_len = 3; dma_wdata = 64'hD0;
    exp_gnt(0, 64'h80, 1, 64'h1111, 4, cyc);
    tick();
    exp_gnt(1, 64'h100, 1, 64'hD0, 8, cyc);
    for (int k = 1; k < 4; k++) begin
      tick();
      dma_wdata = 64'hD0 + 64'(k);
      dma_addr = 64'hDEAD;
      dma_xfer_size = XFER_B;
      exp_gnt(1, 64'h100 + 64'(8 * k), 1, dma_wdata, 8, cyc);
    end
    tick();
    dma_req = 0;
    exp_gnt(0, 64'h80, 1, 64'h1111, 4, cyc);
    q_done.push_back(cyc);
    tick();
    cpu_req = 0;

    // CPU read, 1-cycle latency
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'd128;
    cpu_xfer_size = XFER_D; rd_val = 64'd69;
    exp_gnt(0, 64'd128, 0, 64'h1111, 8, cyc);
    exp_rd(0, 64'd69, cyc + 1);
    tick();
    cpu_req = 0;

    // address wrap on a read burst
    tick();
    dma_req = 1; dma_we = 0; dma_addr = 64'hFFFF_FFFF_FFFF_FFF8;
    dma_xfer_size = XFER_D; dma_len = 1; rd_val = 64'h11;
    exp_gnt(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, dma_wdata, 8, cyc);
    exp_rd(1, 64'h11, cyc + 1);
    tick();
    rd_val = 64'h22;
    exp_gnt(1, 64'h0, 0, dma_wdata, 8, cyc);
    exp_rd(1, 64'h22, cyc + 1);
    q_done.push_back(cyc + 1);
    tick();
    dma_req = 0;

    // size 0 gives a constant address
    tick();
    dma_req = 1; dma_we = 1; dma_addr = 64'h50;
    dma_xfer_size = 4'd0; dma_len = 1; dma_wdata = 64'h5;
    exp_gnt(1, 64'h50, 1, 64'h5, 0, cyc);
    tick();
    dma_wdata = 64'h6;
    exp_gnt(1, 64'h50, 1, 64'h6, 0, cyc);
    q_done.push_back(cyc + 1);
    tick();
    dma_req = 0;

    // reset after 2 of 4 beats
    tick();
    dma_req = 1; dma_we = 1; dma_addr = 64'h200;
    dma_xfer_size = XFER_W; dma_len = 3; dma_wdata = 64'h7;
    exp_gnt(1, 64'h200, 1, 64'h7, 4, cyc);
    tick();
    dma_wdata = 64'h8;
    exp_gnt(1, 64'h204, 1, 64'h8, 4, cyc);
    tick();
    reset = 1;
    tick();
    reset = 0; dma_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h40;
    cpu_xfer_size = XFER_D; rd_val = 64'h77;
    exp_gnt(0, 64'h40, 0, 64'h1111, 8, cyc);
    exp_rd(0, 64'h77, cyc + 1);
    @(negedge clk);
    chk("rst_mid_cpu_rdata", cpu_rdata, 64'd0);
    chk("rst_mid_dma_rdata", dma_rdata, 64'd0);
    tick();
    cpu_req = 0;

    // abort: dma_req dropped at beat 2 of 4
    tick();
    dma_req = 1; dma_we = 0; dma_addr = 64'h300;
    dma_xfer_size = XFER_H; dma_len = 3; rd_val = 64'hA1;
    exp_gnt(1, 64'h300, 0, dma_wdata, 2, cyc);
    exp_rd(1, 64'hA1, cyc + 1);
    tick();
    rd_val = 64'hA2;
    exp_gnt(1, 64'h302, 0, dma_wdata, 2, cyc);
    exp_rd(1, 64'hA2, cyc + 1);
    tick();
    dma_req = 0;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 64'h48;
    cpu_xfer_size = XFER_D; rd_val = 64'h5A;
    exp_gnt(0, 64'h48, 0, 64'h1111, 8, cyc);
    exp_rd(0, 64'h5A, cyc + 1);
    tick();
    cpu_req = 0;
    @(negedge clk);
    chk("dma_rdata_held", dma_rdata, 64'hA2);

    repeat (4) tick();
    chk("left_gnt", 64'(q_gnt.size()), 64'd0);
    chk("left_cpu_rd", 64'(q_crd.size()), 64'd0);
    chk("left_dma_rd", 64'(q_drd.size()), 64'd0);
    chk("left_done", 64'(q_done.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single `datamem` data-memory instance between the CPU memory stage and a DMA/loader port. It decides each cycle which requester drives the memory and registers read data back to the requester that owns it. It also sequences DMA bursts by generating incrementing addresses from a base, a beat count and `xfer_size`. It sits between the memory-stage datapath and `datamem`, replacing the direct hookup.

## Interface
- `DATA_W`, 64, address and data width
- `LEN_W`, 4, width of DMA burst length; maximum burst is 2^LEN_W beats

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `cpu_req`, `cpu_we`  in  1  CPU access request; 1 = store
- `cpu_addr`, `cpu_wdata`  in  DATA_W  CPU address and store data
- `cpu_xfer_size`  in  4  CPU transfer size in bytes
- `cpu_gnt`  out  1  CPU access performed this cycle
- `cpu_rvalid`  out  1  CPU read data valid
- `cpu_rdata`  out  DATA_W  CPU read data
- `dma_req`, `dma_we`  in  1  DMA request and write flag, held for the whole burst
- `dma_addr`, `dma_wdata`  in  DATA_W  burst base address and per-beat write data
- `dma_xfer_size`  in  4  bytes per beat; also the address stride
- `dma_len`  in  LEN_W  beats minus 1
- `dma_gnt`  out  1  DMA beat performed this cycle
- `dma_rvalid`  out  1  DMA read data valid
- `dma_rdata`  out  DATA_W  DMA read data
- `dma_done`  out  1  one-cycle pulse when a burst completes
- `mem_address`, `mem_write_data`  out  DATA_W  to `datamem`
- `mem_write_enable`, `mem_read_enable`  out  1  to `datamem`
- `mem_xfer_size`  out  4  to `datamem`
- `mem_read_data`  in  DATA_W  from `datamem`; combinational read

## Operation
- **States:** `ARB_IDLE` and `ARB_DMA_BURST`. A `last_owner` flop resets to DMA, so the CPU wins the first tie after reset.
- **ARB_IDLE, single request:** the requester is granted that cycle.
- **ARB_IDLE, both requesting:** grant the owner that is not `last_owner`. Update `last_owner` to the granted side.
- **CPU grant:** always a single beat. State stays `ARB_IDLE`.
- **DMA grant with `dma_len`=0:** single beat. Stays `ARB_IDLE`. `dma_done` pulses on the next cycle.
- **DMA grant with `dma_len`>0:** beat 0 uses `dma_addr`. The block latches base, size, `we` and remaining count = `dma_len`, then moves to `ARB_DMA_BURST`.
- **ARB_DMA_BURST:**
  - Beat k address = base + k*size, computed modulo 2^DATA_W (wraps).
  - `dma_gnt`=1 on every beat; `cpu_gnt`=0 throughout.
  - `dma_wdata` is sampled on each beat.
  - After the last beat: go to `ARB_IDLE`, pulse `dma_done`, set `last_owner`=DMA.
- **`dma_req` low during `ARB_DMA_BURST`:** abort. No beat issues that cycle, the state returns to `ARB_IDLE`, and `dma_done` is not pulsed.
- **`xfer_size` legality:** legal values are 1, 2, 4 and 8. A size of 0 gives a stride of 0, so the address stays constant. Size legality is not checked.
- **Memory drive:**
  - `mem_read_enable` = (any grant) & !we.
  - `mem_write_enable` = (any grant) & we.
  - With no grant: both enables are 0 and `mem_address`, `mem_write_data` and `mem_xfer_size` are 0.
- **Read return:** `mem_read_data` is registered into the owner's `rdata`. Only the owner's `rvalid` rises; the other `rdata` holds its last value.

## Timing
- `cpu_gnt`, `dma_gnt` and all `mem_*` outputs are combinational from state and requests; grant is in the same cycle as the request.
- Writes commit at the clock edge that ends the grant cycle.
- Read latency is 1: `*_rvalid`/`*_rdata` are valid in the cycle after the grant.
- `dma_done` is registered. It is coincident with the last beat's `dma_rvalid` on reads, or one cycle after the last beat on writes.
- A burst of N beats occupies exactly N consecutive cycles. The earliest pending CPU grant is the cycle after the last beat.
- **Reset values:** state `ARB_IDLE`; `last_owner` DMA; burst counter, base and size all 0; `cpu_rvalid`, `dma_rvalid` and `dma_done` 0; `cpu_rdata` and `dma_rdata` 0.
- **Reset mid-burst:** the burst is abandoned at the next edge, with no `dma_done` and no further beats.
- **Reset has priority:** it overrides any simultaneous request.

## Structure
- **Package `dmem_arb_pkg`:**
  - `arb_state_t` {`ARB_IDLE`, `ARB_DMA_BURST`}
  - `arb_owner_t` {`OWN_CPU`, `OWN_DMA`}
  - `LEN_W` default
  - legal xfer size constants
- **Sub-module `burst_addr_gen`:** holds the latched base, size and remaining count. It outputs the beat address and a `last_beat` flag, and has load, step and clear inputs.

## Test plan
- **CPU read:** `cpu_req`=1, `we`=0, addr 128, `mem_read_data`=69 -> `cpu_gnt` and `mem_address`=128 the same cycle; `cpu_rvalid`=1 with `cpu_rdata`=69 the next cycle.
- **Tie after reset:** both request single beats with `dma_len`=0 -> CPU granted in cycle 0, DMA in cycle 1, `dma_done` in cycle 2.
- **DMA write burst:** base 0x100, `dma_len`=3, size 8, CPU requesting throughout -> writes to 0x100, 0x108, 0x110, 0x118 on cycles 0-3; `cpu_gnt`=0 for those cycles; CPU granted in cycle 4; `dma_done` in cycle 4.
- **Address wrap:** base 0xFFFFFFFFFFFFFFF8, `dma_len`=1, size 8 -> beat addresses ...FFF8 then 0x0.
- **Reset mid-burst:** reset asserted after 2 of 4 beats -> next cycle both enables 0, state idle, no `dma_done`; a following CPU request is granted immediately.
- **DMA abort:** `dma_req` dropped at beat 2 of 4 -> no beat that cycle, `dma_done` stays 0, and the arbiter accepts new requests the next cycle.
